// File: rtl/input_port_unit.sv
// rtl/input_port_unit.sv - router input port: flit FIFO, XY route compute, output-port request FSM (optional ROUTE_CHECK_EN)
module input_port_unit #(
    parameter int CUR_X      = 1,
    parameter int CUR_Y      = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [31:0]                   in_flit,
    output logic                          in_ready,
    output logic                          req_valid,
    output logic [2:0]                    req_port,
    input  logic                          grant_ack,
    output logic [31:0]                   flit_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          drop_err
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [1:0] CX = 2'(CUR_X);
    localparam logic [1:0] CY = 2'(CUR_Y);

    typedef enum logic [1:0] {S_IDLE, S_ROUTE, S_REQ} state_t;

    state_t          state_q, state_d;
    logic [31:0]     mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [2:0]      req_port_q, req_port_d;
    logic            drop_err_q;

    logic [31:0]     head;
    logic [1:0]      dest_x, dest_y;
    logic [2:0]      route_port;
    logic            push, pop, drop_now;

    assign head   = mem_q[rd_ptr_q];
    assign dest_x = head[3:2];
    assign dest_y = head[1:0];

    // Readiness comes only from the registered count, so a same-cycle pop never frees a slot
    assign in_ready = (count_q < CW'(FIFO_DEPTH));
    assign push     = in_valid && in_ready;

    // Dimension-ordered routing: resolve X first, then Y, then deliver locally
    always_comb begin
        route_port = 3'd4;
        if (dest_x > CX)      route_port = 3'd1;
        else if (dest_x < CX) route_port = 3'd3;
        else if (dest_y > CY) route_port = 3'd2;
        else if (dest_y < CY) route_port = 3'd0;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state logic; leaving REQ/ROUTE on a pop looks at the pre-pop count
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (count_q != '0) state_d = S_ROUTE;
            S_ROUTE: begin
                if (drop_now) state_d = (count_q > CW'(1)) ? S_ROUTE : S_IDLE;
                else          state_d = S_REQ;
            end
            S_REQ:   if (grant_ack) state_d = (count_q > CW'(1)) ? S_ROUTE : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: request, crossbar data, and head pop/drop strobes
    always_comb begin
        req_valid = 1'b0;
        flit_out  = 32'd0;
        pop       = 1'b0;
        drop_now  = 1'b0;
        case (state_q)
            S_REQ: begin
                req_valid = 1'b1;
                flit_out  = head;
                pop       = grant_ack;
            end
            S_ROUTE: begin
`ifdef ROUTE_CHECK_EN
                drop_now = (dest_x > 2'd2) || (dest_y > 2'd2);
                pop      = drop_now;
`endif
            end
            default: ;
        endcase
    end

    // Port decision is captured leaving ROUTE and held for the whole REQ phase
    always_comb begin
        req_port_d = req_port_q;
        if (state_q == S_ROUTE && !drop_now) req_port_d = route_port;
    end

    // Pointer and occupancy next-state with circular wrap
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        count_d = count_q + CW'(push) - CW'(pop);
    end

    // Control registers; reset flushes the buffer regardless of push/pop/grant
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            req_port_q <= 3'd0;
            drop_err_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            req_port_q <= req_port_d;
            drop_err_q <= drop_now;
        end
    end

    // Flit storage; contents are don't-care once pointers are flushed
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_flit;
    end

    assign req_port   = req_port_q;
    assign fifo_count = count_q;
`ifdef ROUTE_CHECK_EN
    assign drop_err   = drop_err_q;
`else
    assign drop_err   = 1'b0;
`endif

endmodule

// File: tb/tb_input_port_unit.sv
// tb/tb_input_port_unit.sv - directed self-checking bench for input_port_unit
module tb_input_port_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_flit;
    logic        in_ready;
    logic        req_valid;
    logic [2:0]  req_port;
    logic        grant_ack;
    logic [31:0] flit_out;
    logic [2:0]  fifo_count;
    logic        drop_err;

    int errors = 0;
    int checks = 0;

    input_port_unit #(.CUR_X(1), .CUR_Y(1), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_flit    (in_flit),
        .in_ready   (in_ready),
        .req_valid  (req_valid),
        .req_port   (req_port),
        .grant_ack  (grant_ack),
        .flit_out   (flit_out),
        .fifo_count (fifo_count),
        .drop_err   (drop_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_flit = '0; grant_ack = 1'b0;
        tick; tick;
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1)      begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (fifo_count !== 3'd0)    begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        checks++; if (req_valid !== 1'b0)     begin errors++; $display("FAIL reset_req_valid: got %b expected 0", req_valid); end
        checks++; if (req_port !== 3'd0)      begin errors++; $display("FAIL reset_req_port: got %0d expected 0", req_port); end
        checks++; if (flit_out !== 32'd0)     begin errors++; $display("FAIL reset_flit_out: got %h expected 0", flit_out); end
        checks++; if (drop_err !== 1'b0)      begin errors++; $display("FAIL reset_drop_err: got %b expected 0", drop_err); end
    endtask

    task automatic test_single;
        in_valid = 1'b1; in_flit = 32'hCAFE_0009; grant_ack = 1'b1;
        tick;
        in_valid = 1'b0;
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL single_count_push: got %0d expected 1", fifo_count); end
        checks++; if (req_valid !== 1'b0)  begin errors++; $display("FAIL single_rv_idle: got %b expected 0", req_valid); end
        tick;
        checks++; if (req_valid !== 1'b0)  begin errors++; $display("FAIL single_rv_route: got %b expected 0", req_valid); end
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL single_grant_ignored: got %0d expected 1", fifo_count); end
        tick;
        checks++; if (req_valid !== 1'b1)  begin errors++; $display("FAIL single_rv_req: got %b expected 1", req_valid); end
        checks++; if (req_port !== 3'd1)   begin errors++; $display("FAIL single_port: got %0d expected 1", req_port); end
        checks++; if (flit_out !== 32'hCAFE_0009) begin errors++; $display("FAIL single_flit: got %h expected cafe0009", flit_out); end
        tick;
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL single_pop: got %0d expected 0", fifo_count); end
        checks++; if (req_valid !== 1'b0)  begin errors++; $display("FAIL single_rv_after: got %b expected 0", req_valid); end
        checks++; if (flit_out !== 32'd0)  begin errors++; $display("FAIL single_flit_after: got %h expected 0", flit_out); end
        tick;
        checks++; if (req_valid !== 1'b0)  begin errors++; $display("FAIL single_idle: got %b expected 0", req_valid); end
        grant_ack = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [31:0] flits [3];
        logic [2:0]  ports [3];
        flits[0] = 32'h1111_0005; ports[0] = 3'd4;
        flits[1] = 32'h2222_0004; ports[1] = 3'd0;
        flits[2] = 32'h3333_0002; ports[2] = 3'd3;
        grant_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_flit = flits[i];
            tick;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL b2b_rv[%0d]: got %b expected 1", i, req_valid); end
            checks++; if (req_port !== ports[i]) begin errors++; $display("FAIL b2b_port[%0d]: got %0d expected %0d", i, req_port, ports[i]); end
            checks++; if (flit_out !== flits[i]) begin errors++; $display("FAIL b2b_flit[%0d]: got %h expected %h", i, flit_out, flits[i]); end
            checks++; if (fifo_count !== 3'(3 - i)) begin errors++; $display("FAIL b2b_count[%0d]: got %0d expected %0d", i, fifo_count, 3 - i); end
            grant_ack = 1'b1;
            tick;
            grant_ack = 1'b0;
            checks++; if (fifo_count !== 3'(2 - i)) begin errors++; $display("FAIL b2b_count_pop[%0d]: got %0d expected %0d", i, fifo_count, 2 - i); end
            checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL b2b_rv_gap[%0d]: got %b expected 0", i, req_valid); end
            if (i < 2) tick;
        end
    endtask

    task automatic test_full;
        logic [31:0] f [5];
        for (int i = 0; i < 5; i++) f[i] = 32'hF000_0005 + (i << 8);
        grant_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_flit = f[i];
            tick;
            checks++; if (fifo_count !== 3'(i + 1)) begin errors++; $display("FAIL full_count[%0d]: got %0d expected %0d", i, fifo_count, i + 1); end
        end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b expected 0", in_ready); end
        in_flit = f[4];
        tick;
        in_valid = 1'b0;
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_fifth_ignored: got %0d expected 4", fifo_count); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (flit_out !== f[i]) begin errors++; $display("FAIL full_drain[%0d]: got %h expected %h", i, flit_out, f[i]); end
            grant_ack = 1'b1;
            tick;
            grant_ack = 1'b0;
            if (i < 3) tick;
        end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL full_empty: got %0d expected 0", fifo_count); end
        tick;
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL full_no_fifth: got %b expected 0", req_valid); end
    endtask

    task automatic test_hold;
        grant_ack = 1'b0;
        in_valid = 1'b1; in_flit = 32'h1234_5601;
        tick;
        in_valid = 1'b0;
        tick; tick;
        for (int k = 0; k < 5; k++) begin
            checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL hold_rv[%0d]: got %b expected 1", k, req_valid); end
            checks++; if (req_port !== 3'd3)  begin errors++; $display("FAIL hold_port[%0d]: got %0d expected 3", k, req_port); end
            checks++; if (flit_out !== 32'h1234_5601) begin errors++; $display("FAIL hold_flit[%0d]: got %h expected 12345601", k, flit_out); end
            in_valid = (k == 0); in_flit = 32'hABCD_0006;
            tick;
        end
        in_valid = 1'b0;
        checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL hold_count: got %0d expected 2", fifo_count); end
        grant_ack = 1'b1;
        tick;
        grant_ack = 1'b0;
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL hold_pop: got %0d expected 1", fifo_count); end
        tick;
        checks++; if (req_port !== 3'd2)  begin errors++; $display("FAIL hold_port2: got %0d expected 2", req_port); end
        checks++; if (flit_out !== 32'hABCD_0006) begin errors++; $display("FAIL hold_flit2: got %h expected abcd0006", flit_out); end
        grant_ack = 1'b1;
        tick;
        grant_ack = 1'b0;
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL hold_empty: got %0d expected 0", fifo_count); end
    endtask

    task automatic test_reset_mid;
        grant_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_flit = 32'h5000_0009 + (i << 12);
            tick;
        end
        checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_rv: got %b expected 1", req_valid); end
        checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL rstmid_pre_count: got %0d expected 3", fifo_count); end
        rst = 1'b1; grant_ack = 1'b1;
        tick;
        rst = 1'b0; in_valid = 1'b0; grant_ack = 1'b0;
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rstmid_count: got %0d expected 0", fifo_count); end
        checks++; if (req_valid !== 1'b0)  begin errors++; $display("FAIL rstmid_rv: got %b expected 0", req_valid); end
        checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL rstmid_ready: got %b expected 1", in_ready); end
        checks++; if (req_port !== 3'd0)   begin errors++; $display("FAIL rstmid_port: got %0d expected 0", req_port); end
        tick; tick;
        checks++; if (req_valid !== 1'b0)  begin errors++; $display("FAIL rstmid_idle: got %b expected 0", req_valid); end
    endtask

    task automatic test_route_check;
        grant_ack = 1'b0;
        in_valid = 1'b1; in_flit = 32'h0000_000D;
        tick;
        in_valid = 1'b0;
        checks++; if (drop_err !== 1'b0) begin errors++; $display("FAIL rc_drop_early: got %b expected 0", drop_err); end
        tick; tick;
`ifdef ROUTE_CHECK_EN
        checks++; if (drop_err !== 1'b1)   begin errors++; $display("FAIL rc_drop_pulse: got %b expected 1", drop_err); end
        checks++; if (req_valid !== 1'b0)  begin errors++; $display("FAIL rc_no_req: got %b expected 0", req_valid); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rc_count: got %0d expected 0", fifo_count); end
        tick;
        checks++; if (drop_err !== 1'b0)   begin errors++; $display("FAIL rc_drop_end: got %b expected 0", drop_err); end
        checks++; if (req_valid !== 1'b0)  begin errors++; $display("FAIL rc_no_req2: got %b expected 0", req_valid); end
`else
        checks++; if (drop_err !== 1'b0)   begin errors++; $display("FAIL rc_drop_tied: got %b expected 0", drop_err); end
        checks++; if (req_valid !== 1'b1)  begin errors++; $display("FAIL rc_req: got %b expected 1", req_valid); end
        checks++; if (req_port !== 3'd1)   begin errors++; $display("FAIL rc_port: got %0d expected 1", req_port); end
        grant_ack = 1'b1;
        tick;
        grant_ack = 1'b0;
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rc_count: got %0d expected 0", fifo_count); end
`endif
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_full;
        test_hold;
        test_reset_mid;
        test_route_check;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
